// File: rtl/spinner_pkg.sv
// Shared constants for the spinner controller.
// Clamp mode encoding and guard widths for the saturating adders.
package spinner_pkg;

  localparam int CLAMP_WRAP = 0;
  localparam int CLAMP_SAT  = 1;

  localparam int DX_W       = 9;
  localparam int PEND_GUARD = 2;
  localparam int SUM_GUARD  = 3;

endpackage

// File: rtl/spinner_chan.sv
// One spinner channel: angle, pending mouse delta and hold counter.
// Applies button step plus pending delta on each frame edge.
module spinner_chan
  import spinner_pkg::*;
#(
  parameter int ANGLE_W      = 8,
  parameter int STEP         = 1,
  parameter int FAST_STEP    = 4,
  parameter int ACCEL_FRAMES = 16,
  parameter int CLAMP        = 0
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     frame,
  input  logic                     plus,
  input  logic                     minus,
  input  logic                     fast,
  input  logic                     enable,
  input  logic                     mouse_valid,
  input  logic signed [DX_W-1:0]   mouse_delta,
  output logic        [ANGLE_W-1:0] angle,
  output logic                     moved
);

  localparam int PEND_W = ANGLE_W + PEND_GUARD;
  localparam int ACC_W  = ((PEND_W > DX_W) ? PEND_W : DX_W) + 1;
  localparam int SUM_W  = PEND_W + SUM_GUARD;
  localparam int HOLD_W = $clog2(ACCEL_FRAMES + 2);

  logic signed [PEND_W-1:0] pending;
  logic signed [PEND_W-1:0] pend_next;
  logic        [HOLD_W-1:0] hold;
  logic        [HOLD_W-1:0] hold_eff;
  logic        [HOLD_W-1:0] hold_next;
  logic                     last_dir;
  logic                     dir_req;
  logic                     reversal;
  logic                     use_fast;
  logic signed [SUM_W-1:0]  step_s;
  logic signed [SUM_W-1:0]  button;
  logic signed [SUM_W-1:0]  sum;
  logic signed [SUM_W-1:0]  amax;
  logic signed [ACC_W-1:0]  base;
  logic signed [ACC_W-1:0]  acc;
  logic signed [ACC_W-1:0]  pmax;
  logic signed [ACC_W-1:0]  pmin;
  logic        [ANGLE_W-1:0] angle_next;

  // A reversal restarts acceleration from this frame.
  assign dir_req  = plus ^ minus;
  assign reversal = dir_req && (hold != '0) && (plus != last_dir);
  assign hold_eff = reversal ? '0 : hold;
  assign use_fast = fast || (hold_eff >= HOLD_W'(ACCEL_FRAMES));
  assign step_s   = use_fast ? SUM_W'(FAST_STEP) : SUM_W'(STEP);
  assign button   = !dir_req ? '0 : (plus ? step_s : -step_s);

  assign sum = $signed({{(SUM_W-ANGLE_W){1'b0}}, angle})
             + button
             + $signed({{(SUM_W-PEND_W){pending[PEND_W-1]}}, pending});
  assign amax = $signed({{(SUM_W-ANGLE_W){1'b0}}, {ANGLE_W{1'b1}}});

  always_comb begin
    angle_next = sum[ANGLE_W-1:0];
    if (CLAMP == CLAMP_SAT) begin
      if (sum[SUM_W-1])
        angle_next = '0;
      else if (sum > amax)
        angle_next = '1;
    end
  end

  assign pmax = $signed({{(ACC_W-PEND_W+1){1'b0}}, {(PEND_W-1){1'b1}}});
  assign pmin = $signed({{(ACC_W-PEND_W+1){1'b1}}, {(PEND_W-1){1'b0}}});
  assign base = frame ? '0
              : $signed({{(ACC_W-PEND_W){pending[PEND_W-1]}}, pending});
  assign acc  = base
              + $signed({{(ACC_W-DX_W){mouse_delta[DX_W-1]}}, mouse_delta});

  // A delta arriving on the frame edge lands in the freshly cleared pending.
  always_comb begin
    pend_next = base[PEND_W-1:0];
    if (mouse_valid) begin
      if (acc > pmax)
        pend_next = pmax[PEND_W-1:0];
      else if (acc < pmin)
        pend_next = pmin[PEND_W-1:0];
      else
        pend_next = acc[PEND_W-1:0];
    end
  end

  always_comb begin
    hold_next = '0;
    if (dir_req) begin
      if (hold_eff == HOLD_W'(ACCEL_FRAMES))
        hold_next = hold_eff;
      else
        hold_next = hold_eff + 1'b1;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      angle    <= '0;
      pending  <= '0;
      hold     <= '0;
      last_dir <= 1'b0;
      moved    <= 1'b0;
    end else begin
      moved <= 1'b0;
      if (!enable) begin
        pending  <= '0;
        hold     <= '0;
        last_dir <= 1'b0;
      end else begin
        pending <= pend_next;
        if (frame) begin
          angle <= angle_next;
          moved <= (angle_next != angle);
          hold  <= hold_next;
          if (dir_req)
            last_dir <= plus;
        end
      end
    end
  end

endmodule

// File: rtl/spinner_ctrl.sv
// Multi-channel spinner controller top.
// Frame edge detect and mouse delta demux feeding per-channel units.
module spinner_ctrl
  import spinner_pkg::*;
#(
  parameter int CHANNELS     = 2,
  parameter int ANGLE_W      = 8,
  parameter int STEP         = 1,
  parameter int FAST_STEP    = 4,
  parameter int ACCEL_FRAMES = 16,
  parameter int MOUSE_SHIFT  = 0,
  parameter int CLAMP        = 0
) (
  input  logic                          clk,
  input  logic                          reset,
  input  logic                          strobe,
  input  logic [CHANNELS-1:0]           plus,
  input  logic [CHANNELS-1:0]           minus,
  input  logic [CHANNELS-1:0]           fast,
  input  logic [CHANNELS-1:0]           enable,
  input  logic                          mouse_strobe,
  input  logic signed [DX_W-1:0]        mouse_dx,
  input  logic [1:0]                    mouse_sel,
  output logic [CHANNELS*ANGLE_W-1:0]   angle,
  output logic [CHANNELS-1:0]           moved
);

  logic                   strobe_q;
  logic                   primed;
  logic                   frame;
  logic signed [DX_W-1:0] dx;

  // primed masks the first cycle after reset so a high strobe is not an edge.
  assign frame = strobe && !strobe_q && primed;
  assign dx    = mouse_dx >>> MOUSE_SHIFT;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      strobe_q <= 1'b0;
      primed   <= 1'b0;
    end else begin
      strobe_q <= strobe;
      primed   <= 1'b1;
    end
  end

  for (genvar g = 0; g < CHANNELS; g++) begin : g_chan
    spinner_chan #(
      .ANGLE_W      (ANGLE_W),
      .STEP         (STEP),
      .FAST_STEP    (FAST_STEP),
      .ACCEL_FRAMES (ACCEL_FRAMES),
      .CLAMP        (CLAMP)
    ) u_chan (
      .clk         (clk),
      .reset       (reset),
      .frame       (frame),
      .plus        (plus[g]),
      .minus       (minus[g]),
      .fast        (fast[g]),
      .enable      (enable[g]),
      .mouse_valid (mouse_strobe && (mouse_sel == 2'(g))),
      .mouse_delta (dx),
      .angle       (angle[g*ANGLE_W +: ANGLE_W]),
      .moved       (moved[g])
    );
  end

endmodule

// File: doc/spinner_ctrl.md
SPINNER_CTRL -- requirements
Module: spinner_ctrl

Interface
REQ-001 SHALL have parameter CHANNELS, default 2, number of independent spinner channels (1..4).
REQ-002 SHALL have parameter ANGLE_W, default 8, angle width per channel in bits (4..12).
REQ-003 SHALL have parameter STEP, default 1, normal per-frame button step.
REQ-004 SHALL have parameter FAST_STEP, default 4, per-frame step when fast or accelerated.
REQ-005 SHALL have parameter ACCEL_FRAMES, default 16, consecutive held frames before auto-fast.
REQ-006 SHALL have parameter MOUSE_SHIFT, default 0, arithmetic right shift applied to mouse deltas.
REQ-007 SHALL have parameter CLAMP, default 0; 0 = angle wraps, 1 = angle saturates.
REQ-008 SHALL have port clk, input, 1, the single system clock; all logic is clocked on its rising edge.
REQ-009 SHALL have port reset, input, 1, asynchronous active-high reset.
REQ-010 SHALL have port strobe, input, 1, frame tick (vsync); each rising edge triggers one update.
REQ-011 SHALL have port plus, input, CHANNELS, per-channel clockwise request.
REQ-012 SHALL have port minus, input, CHANNELS, per-channel counter-clockwise request.
REQ-013 SHALL have port fast, input, CHANNELS, per-channel forced fast step.
REQ-014 SHALL have port enable, input, CHANNELS, per-channel enable.
REQ-015 SHALL have port mouse_strobe, input, 1, single-cycle mouse-delta valid.
REQ-016 SHALL have port mouse_dx, input, 9, signed mouse delta.
REQ-017 SHALL have port mouse_sel, input, 2, target channel of mouse delta.
REQ-018 SHALL have port angle, output, CHANNELS*ANGLE_W, packed angles; channel 0 in the LSBs.
REQ-019 SHALL have port moved, output, CHANNELS, one-cycle pulse when a channel angle changed.

Function
REQ-020 SHALL detect a frame edge when strobe=1 and the previous registered sample of strobe=0.
REQ-021 SHALL update angle and moved on the same clk edge at which the frame edge is detected.
REQ-022 SHALL compute the button delta as: +step if plus&~minus; -step if minus&~plus; 0 if both or neither.
REQ-023 SHALL use step=FAST_STEP when fast=1 or hold count>=ACCEL_FRAMES, else step=STEP.
REQ-024 SHALL increment a per-channel hold counter (saturating at ACCEL_FRAMES) on each frame edge with plus^minus=1, and clear it on a frame edge with plus^minus=0 or on a direction reversal.
REQ-025 SHALL, on mouse_strobe, add (mouse_dx>>>MOUSE_SHIFT) to the pending delta of channel mouse_sel; mouse_sel>=CHANNELS is ignored.
REQ-026 SHALL hold pending as signed ANGLE_W+2 bits, saturating at its signed max/min.
REQ-027 SHALL, on a frame edge, add button delta plus pending to angle and clear pending.
REQ-028 SHALL defer a mouse_strobe coinciding with a frame edge, leaving pending equal to that new delta alone.
REQ-029 SHALL wrap angle modulo 2^ANGLE_W when CLAMP=0 and clamp it to [0, 2^ANGLE_W-1] when CLAMP=1.
REQ-030 SHALL, when enable=0, freeze angle, hold pending and the hold counter at 0, and keep moved at 0.
REQ-031 SHALL pulse moved for exactly one cycle, only when the new angle differs from the old one.

Reset
REQ-032 SHALL clear angle, pending, hold counters, moved and the strobe sample to 0 immediately on reset=1.
REQ-033 SHALL detect no frame edge in the first cycle after reset release when strobe is already 1.
REQ-034 SHALL discard any mouse_strobe or frame edge that occurs while reset=1.

Structure
REQ-035 SHALL place the CLAMP mode encoding and the saturating-add width constants in shared package spinner_pkg.
REQ-036 SHALL instantiate one sub-module per channel, spinner_chan, holding the angle, pending and hold registers; the top level holds the strobe edge detect and mouse demux only.

Verification
REQ-037 SHALL verify: plus[0]=1 for 3 frames from reset -> angle[0]=3, moved[0] pulsed 3 times, angle[1]=0.
REQ-038 SHALL verify: plus[0] held for 20 frames -> angle[0]=16*1 + 4*4 = 32; release then press again -> the step returns to 1.
REQ-039 SHALL verify: minus[1]=1, fast[1]=1 for 1 frame from angle 2, CLAMP=0 -> angle[1]=254; with CLAMP=1 -> angle[1]=0 and moved[1]=1.
REQ-040 SHALL verify: mouse_dx=+100 then +100 then -30 to channel 1 between frames -> angle[1]=170 after the next frame; mouse_dx=+100 on the frame-edge cycle -> angle[1] changes by 100 only on the following frame.
REQ-041 SHALL verify: plus=minus=1 -> no change and no moved pulse; enable=0 with mouse input -> angle frozen, pending 0.
REQ-042 SHALL verify: reset asserted mid-frame with pending=50 -> all outputs 0 asynchronously; strobe=1 at reset release -> no update until strobe falls and rises again.
